updn_counter_param: RTL and testbench

Parametrised up/down counter: successor to the fixed 16-bit load/up/down/enable counter. Adds a configurable width, a programmable modulus (MAX_VAL), a variable step size, terminal-count flags and a wrap/clip event pulse. An optional saturating mode is compiled in by macro. Sits in the same datapath slot as the 16-bit counter and drives downstream timers and address generators.

---
 rtl/updn_counter_param.sv | 71 +++++++
 tb/tb_updn_counter_param.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/updn_counter_param.sv
// updn_counter_param: parametrised up/down counter with modulus, variable step, terminal flags and wrap pulse.
// Define UPDN_CNT_SAT_EN to compile in the saturating mode selected per cycle by sat_mode.
module updn_counter_param #(
    parameter int              WIDTH   = 16,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
    parameter int              STEP_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              ld_cnt,
    input  logic              updn_cnt,
    input  logic              count_enb,
    input  logic [STEP_W-1:0] step,
    input  logic              sat_mode,
    output logic [WIDTH-1:0]  data_out,
    output logic              tc_up,
    output logic              tc_dn,
    output logic              wrap_p
);
    logic [WIDTH-1:0] r_cnt;
    logic             r_wrap;
    logic [WIDTH:0]   w_max, w_mod, w_cur, w_step, w_s, w_sum, w_nxt_up, w_nxt_dn, w_nxt;
    logic [WIDTH-1:0] w_ld;
    logic             w_over, w_under, w_hit, w_sat, w_unused_msb;

    // All count arithmetic is one bit wider than the register so sums never overflow.
    assign w_max    = {1'b0, MAX_VAL};
    assign w_mod    = w_max + {{WIDTH{1'b0}}, 1'b1};
    assign w_cur    = {1'b0, r_cnt};
    assign w_step   = {{(WIDTH+1-STEP_W){1'b0}}, step};
    assign w_s      = (w_step > w_max) ? w_max : w_step;
    assign w_sum    = w_cur + w_s;
    assign w_over   = w_sum > w_max;
    assign w_under  = w_cur < w_s;
    assign w_ld     = (data_in > MAX_VAL) ? MAX_VAL : data_in;

`ifdef UPDN_CNT_SAT_EN
    assign w_sat    = sat_mode;
`else
    logic w_unused_sat;
    assign w_unused_sat = sat_mode;
    assign w_sat    = 1'b0;
`endif

    assign w_nxt_up = w_over ? (w_sat ? w_max : w_sum - w_mod) : w_sum;
    assign w_nxt_dn = w_under ? (w_sat ? '0 : w_cur + w_mod - w_s) : w_cur - w_s;
    assign w_nxt    = updn_cnt ? w_nxt_up : w_nxt_dn;
    assign w_hit    = updn_cnt ? w_over : w_under;
    assign w_unused_msb = w_nxt[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (ld_cnt) begin
            r_cnt  <= w_ld;
            r_wrap <= 1'b0;
        end else if (count_enb) begin
            r_cnt  <= w_nxt[WIDTH-1:0];
            r_wrap <= w_hit;
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign data_out = r_cnt;
    assign wrap_p   = r_wrap;
    assign tc_up    = r_cnt == MAX_VAL;
    assign tc_dn    = r_cnt == '0;
endmodule

// File: tb/tb_updn_counter_param.sv
// tb_updn_counter_param: directed vector table plus randomized run against an integer reference model.
module tb_updn_counter_param;
    localparam int WIDTH  = 16;
    localparam int MAXV   = 9;
    localparam int STEP_W = 4;
`ifdef UPDN_CNT_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef struct {
        bit        r;
        bit        ld;
        int        din;
        bit        up;
        bit        en;
        int        st;
        bit        sat;
        int        exp_cnt;
        bit        exp_wrap;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [WIDTH-1:0]  data_in = '0;
    logic              ld_cnt = 1'b0;
    logic              updn_cnt = 1'b0;
    logic              count_enb = 1'b0;
    logic [STEP_W-1:0] step = '0;
    logic              sat_mode = 1'b0;
    logic [WIDTH-1:0]  data_out;
    logic              tc_up, tc_dn, wrap_p;

    int n_pass = 0;
    int n_total = 0;
    int m_cnt = 0;
    bit m_wrap = 1'b0;
    vec_t vt[22];

    always #5 clk = ~clk;

    updn_counter_param #(.WIDTH(WIDTH), .MAX_VAL(16'(MAXV)), .STEP_W(STEP_W)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .ld_cnt(ld_cnt), .updn_cnt(updn_cnt),
        .count_enb(count_enb), .step(step), .sat_mode(sat_mode),
        .data_out(data_out), .tc_up(tc_up), .tc_dn(tc_dn), .wrap_p(wrap_p)
    );

    function automatic vec_t mk(bit r, bit ld, int din, bit up, bit en, int st, bit sat, int ec, bit ew);
        vec_t v;
        v.r = r; v.ld = ld; v.din = din; v.up = up; v.en = en; v.st = st; v.sat = sat;
        v.exp_cnt = ec; v.exp_wrap = ew;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic drive(input vec_t v);
        rst = v.r; ld_cnt = v.ld; data_in = WIDTH'(v.din); updn_cnt = v.up;
        count_enb = v.en; step = STEP_W'(v.st); sat_mode = v.sat;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int ec, input bit ew);
        chk({tag, " data_out"}, int'(data_out), ec);
        chk({tag, " wrap_p"}, int'(wrap_p), int'(ew));
        chk({tag, " tc_up"}, int'(tc_up), int'(ec == MAXV));
        chk({tag, " tc_dn"}, int'(tc_dn), int'(ec == 0));
    endtask

    // Reference behaviour straight from the counting rules, in plain integers.
    task automatic model(input vec_t v);
        int s, n;
        if (v.r) begin
            m_cnt = 0; m_wrap = 0;
        end else if (v.ld) begin
            m_cnt = (v.din > MAXV) ? MAXV : v.din; m_wrap = 0;
        end else if (v.en) begin
            s = (v.st > MAXV) ? MAXV : v.st;
            n = v.up ? m_cnt + s : m_cnt - s;
            m_wrap = (n > MAXV) || (n < 0);
            if (n > MAXV) n = (SAT_EN && v.sat) ? MAXV : n - (MAXV + 1);
            else if (n < 0) n = (SAT_EN && v.sat) ? 0 : n + MAXV + 1;
            m_cnt = n;
        end else begin
            m_wrap = 0;
        end
    endtask

    initial begin
        vec_t v;
        vt[0]  = mk(1, 1, 5,  0, 0, 0, 0, 0, 0);
        vt[1]  = mk(0, 1, 7,  0, 0, 0, 0, 7, 0);
        vt[2]  = mk(0, 0, 0,  1, 1, 1, 0, 8, 0);
        vt[3]  = mk(0, 0, 0,  1, 1, 1, 0, 9, 0);
        vt[4]  = mk(0, 0, 0,  1, 1, 1, 0, 0, 1);
        vt[5]  = mk(0, 0, 0,  1, 1, 1, 0, 1, 0);
        vt[6]  = mk(0, 0, 0,  0, 1, 3, 0, 8, 1);
        vt[7]  = mk(0, 0, 0,  0, 1, 3, 0, 5, 0);
        vt[8]  = mk(0, 1, 15, 1, 1, 1, 0, 9, 0);
        vt[9]  = mk(0, 0, 0,  1, 1, 1, 0, 0, 1);
        vt[10] = mk(1, 0, 0,  1, 1, 5, 0, 0, 0);
        vt[11] = mk(0, 1, 4,  0, 0, 0, 0, 4, 0);
        vt[12] = mk(0, 0, 0,  1, 1, 0, 0, 4, 0);
        vt[13] = mk(0, 0, 0,  0, 1, 0, 0, 4, 0);
        vt[14] = mk(0, 0, 0,  1, 1, 0, 1, 4, 0);
        vt[15] = mk(0, 0, 0,  1, 0, 7, 0, 4, 0);
        vt[16] = mk(0, 0, 0,  0, 0, 7, 1, 4, 0);
        vt[17] = mk(0, 0, 0,  1, 0, 3, 0, 4, 0);
        vt[18] = mk(0, 1, 8,  1, 0, 0, 1, 8, 0);
`ifdef UPDN_CNT_SAT_EN
        vt[19] = mk(0, 0, 0,  1, 1, 3, 1, 9, 1);
        vt[20] = mk(0, 0, 0,  1, 1, 3, 1, 9, 1);
        vt[21] = mk(0, 0, 0,  0, 1, 15, 1, 0, 0);
`else
        vt[19] = mk(0, 0, 0,  1, 1, 3, 1, 1, 1);
        vt[20] = mk(0, 0, 0,  1, 1, 3, 1, 4, 0);
        vt[21] = mk(0, 0, 0,  0, 1, 15, 1, 5, 1);
`endif
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 22; i++) begin
            drive(vt[i]);
            check_out($sformatf("vec%0d", i), vt[i].exp_cnt, vt[i].exp_wrap);
        end

        // Reset mid-count, then the first count after release starts from 0.
        drive(mk(0, 1, 6, 0, 0, 0, 0, 0, 0));
        drive(mk(1, 0, 0, 1, 1, 2, 0, 0, 0));
        check_out("rst_mid", 0, 0);
        drive(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
        check_out("post_rst_down", MAXV, 1);

        m_cnt = MAXV; m_wrap = 1;
        for (int i = 0; i < 3000; i++) begin
            v.r   = ($urandom_range(0, 49) == 0);
            v.ld  = ($urandom_range(0, 7) == 0);
            v.din = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 12));
            v.up  = $urandom_range(0, 1) == 1;
            v.en  = $urandom_range(0, 3) != 0;
            v.st  = $urandom_range(0, 15);
            v.sat = $urandom_range(0, 1) == 1;
            drive(v);
            model(v);
            check_out("rand", m_cnt, m_wrap);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
